button_conditioner: RTL



---
 rtl/button_conditioner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Debounces one synchronized push-button level and emits registered
// press / release / click / long / repeat pulses for the timer control FSM.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 100000000,
   parameter int REPEAT_CYCLES   = 20000000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic IN,
   output logic LEVEL,
   output logic PRESS,
   output logic RELEASE,
   output logic CLICK,
   output logic LONG,
   output logic REPEAT
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam int RW = $clog2(REPEAT_CYCLES + 1);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      HELD,
      LONG_HELD,
      RELEASE_DB
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] deb_cnt, deb_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [RW-1:0] rep_cnt, rep_nxt;
   logic          long_flag, flag_nxt;
   logic          level_nxt, press_nxt, release_nxt;
   logic          click_nxt, long_nxt, repeat_nxt;

   always_comb begin
      state_nxt   = state;
      deb_nxt     = deb_cnt;
      hold_nxt    = hold_cnt;
      rep_nxt     = rep_cnt;
      flag_nxt    = long_flag;
      level_nxt   = LEVEL;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      click_nxt   = 1'b0;
      long_nxt    = 1'b0;
      repeat_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (IN) begin
               state_nxt = PRESS_DB;
               deb_nxt   = DW'(1);
            end
         end
         PRESS_DB: begin
            if (!IN) begin
               state_nxt = IDLE;
               deb_nxt   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = HELD;
               deb_nxt   = '0;
               hold_nxt  = '0;
               flag_nxt  = 1'b0;
               level_nxt = 1'b1;
               press_nxt = 1'b1;
            end else begin
               deb_nxt = deb_cnt + DW'(1);
            end
         end
         HELD: begin
            // the release edge itself still counts as a held cycle
            if (!IN) begin
               state_nxt = RELEASE_DB;
               deb_nxt   = DW'(1);
               if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + HW'(1);
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = LONG_HELD;
               long_nxt  = 1'b1;
               flag_nxt  = 1'b1;
               rep_nxt   = '0;
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
         end
         LONG_HELD: begin
            if (!IN) begin
               state_nxt = RELEASE_DB;
               deb_nxt   = DW'(1);
               if (rep_cnt != REP_LAST) rep_nxt = rep_cnt + RW'(1);
            end else if (rep_cnt == REP_LAST) begin
               repeat_nxt = 1'b1;
               rep_nxt    = '0;
            end else begin
               rep_nxt = rep_cnt + RW'(1);
            end
         end
         RELEASE_DB: begin
            if (IN) begin
               state_nxt = long_flag ? LONG_HELD : HELD;
               deb_nxt   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt   = IDLE;
               deb_nxt     = '0;
               hold_nxt    = '0;
               rep_nxt     = '0;
               flag_nxt    = 1'b0;
               level_nxt   = 1'b0;
               release_nxt = 1'b1;
               click_nxt   = !long_flag;
            end else begin
               deb_nxt = deb_cnt + DW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= IDLE;
         deb_cnt   <= '0;
         hold_cnt  <= '0;
         rep_cnt   <= '0;
         long_flag <= 1'b0;
         LEVEL     <= 1'b0;
         PRESS     <= 1'b0;
         RELEASE   <= 1'b0;
         CLICK     <= 1'b0;
         LONG      <= 1'b0;
         REPEAT    <= 1'b0;
      end else begin
         state     <= state_nxt;
         deb_cnt   <= deb_nxt;
         hold_cnt  <= hold_nxt;
         rep_cnt   <= rep_nxt;
         long_flag <= flag_nxt;
         LEVEL     <= level_nxt;
         PRESS     <= press_nxt;
         RELEASE   <= release_nxt;
         CLICK     <= click_nxt;
         LONG      <= long_nxt;
         REPEAT    <= repeat_nxt;
      end
   end

endmodule
